// File: rtl/lcd_write_sequencer.sv
// One HD44780 byte write: setup, E strobe, hold, then the execution wait, all timed in tick pulses.
// Every output is registered; lcd_rs/lcd_db come straight from the latched request.
module lcd_write_sequencer #(
  parameter int SETUP_TICKS      = 1,
  parameter int PULSE_TICKS      = 2,
  parameter int HOLD_TICKS       = 1,
  parameter int CMD_WAIT_TICKS   = 10,
  parameter int CLEAR_WAIT_TICKS = 410,
  parameter int CNT_W            = 10
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       start,
  input  logic       rs_in,
  input  logic [7:0] data_in,
  input  logic       tick,
  output logic       timer_enable,
  output logic       timer_disable,
  output logic       busy,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_TICKS - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_TICKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_TICKS - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_TICKS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tcnt_q;
  logic [CNT_W-1:0] wait_last_q;
  logic [CNT_W-1:0] cur_last;
  logic             timed;
  logic             last_tick;
  logic             accept;
  logic             is_clear;
  logic             rs_q;
  logic [7:0]       db_q;
  logic             e_d, busy_d, done_d, ten_d;

  assign timed     = (state_q == S_SETUP) || (state_q == S_PULSE) ||
                     (state_q == S_HOLD)  || (state_q == S_WAIT);
  assign last_tick = timed && tick && (tcnt_q == cur_last);
  assign accept    = (state_q == S_IDLE) && start;
  // Clear display and return home need the long execution time.
  assign is_clear  = !rs_in && ((data_in == 8'h01) || (data_in == 8'h02) || (data_in == 8'h03));

  always_comb begin
    cur_last = '0;
    case (state_q)
      S_SETUP: cur_last = SETUP_LAST;
      S_PULSE: cur_last = PULSE_LAST;
      S_HOLD:  cur_last = HOLD_LAST;
      S_WAIT:  cur_last = wait_last_q;
      default: cur_last = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)     state_d = S_SETUP;
      S_SETUP: if (last_tick) state_d = S_PULSE;
      S_PULSE: if (last_tick) state_d = S_HOLD;
      S_HOLD:  if (last_tick) state_d = S_WAIT;
      S_WAIT:  if (last_tick) state_d = S_DONE;
      S_DONE:                 state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    e_d    = (state_d == S_PULSE);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    ten_d  = (state_d == S_SETUP) || (state_d == S_PULSE) ||
             (state_d == S_HOLD)  || (state_d == S_WAIT);
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      tcnt_q        <= '0;
      wait_last_q   <= CMD_LAST;
      rs_q          <= 1'b0;
      db_q          <= 8'h00;
      lcd_e         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timer_enable  <= 1'b0;
      timer_disable <= 1'b1;
    end else begin
      if (accept) begin
        rs_q        <= rs_in;
        db_q        <= data_in;
        wait_last_q <= is_clear ? CLEAR_LAST : CMD_LAST;
        tcnt_q      <= '0;
      end else if (last_tick || !timed) begin
        tcnt_q <= '0;
      end else if (tick) begin
        tcnt_q <= tcnt_q + CNT_W'(1);
      end
      lcd_e         <= e_d;
      busy          <= busy_d;
      done          <= done_d;
      timer_enable  <= ten_d;
      timer_disable <= !ten_d;
    end
  end

  assign lcd_rs = rs_q;
  assign lcd_db = db_q;
  assign lcd_rw = 1'b0;

endmodule

// File: doc/lcd_write_sequencer.md
# lcd_write_sequencer

Issues one byte write (command or data) to the HD44780-style LCD: drives RS/RW/DB, generates the E strobe, then waits the controller's execution time, with every interval measured in tick pulses from the shared 4 us tick timer. Sits between the LCD init/message FSM (byte requests) and the pins, and owns the tick timer's enable/disable controls.

## Interface
- SETUP_TICKS, 1: ticks RS/DB stable before E rises (>=1)
- PULSE_TICKS, 2: ticks E held high (>=1)
- HOLD_TICKS, 1: ticks DB/RS held after E falls (>=1)
- CMD_WAIT_TICKS, 10: post-write wait, normal commands and data (40 us)
- CLEAR_WAIT_TICKS, 410: post-write wait, clear/home commands (1.64 ms)
- CNT_W, 10: tick counter width; every *_TICKS must be < 2^CNT_W

- clock  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  request pulse; sampled only in IDLE
- rs_in  in  1  0 = command, 1 = data
- data_in  in  8  byte to write
- tick  in  1  one-cycle pulse from tick timer
- timer_enable  out  1  to timer EnableCount
- timer_disable  out  1  to timer DisableCount
- busy  out  1  high from accept until return to IDLE
- done  out  1  one-cycle pulse at end of wait
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write, tied 0 (write only)
- lcd_db  out  8  LCD data bus

## Operation
- States: IDLE, SETUP, PULSE, HOLD, WAIT, DONE. All outputs registered.
- IDLE: `busy=0`, `timer_disable=1`, `timer_enable=0`. On `start=1`, latch `rs_in`/`data_in` into `rs_q`/`db_q`, select the wait length, clear `tcnt`, go to SETUP.
- Wait select at accept: `CLEAR_WAIT_TICKS` if `rs_in=0` and `data_in` is 0x01, 0x02 or 0x03. Otherwise `CMD_WAIT_TICKS`.
- Timed states (SETUP, PULSE, HOLD, WAIT) each have a length N:
  - `tcnt` increments on each cycle with `tick=1`.
  - The state exits on the cycle where `tick=1` and `tcnt==N-1`; `tcnt` clears on exit.
  - Ticks outside timed states are ignored.
- SETUP -> PULSE -> HOLD -> WAIT -> DONE -> IDLE. DONE lasts exactly one cycle.
- Output values per state:
  - `lcd_rs=rs_q` and `lcd_db=db_q` in SETUP, PULSE, HOLD. Both keep their last value in WAIT, DONE and IDLE.
  - `lcd_e=1` only in PULSE.
  - `lcd_rw=0` always.
  - `busy=1` in SETUP through DONE. `done=1` only in DONE.
  - `timer_enable=1` and `timer_disable=0` in SETUP through WAIT. `timer_enable=0` and `timer_disable=1` in DONE and IDLE, so the timer restarts from its seed on every write.
- `start` outside IDLE (including DONE) is ignored; the request is not queued.
- Reset (`rst=0` at a clock edge), from any state including mid-pulse:
  - state goes to IDLE, `tcnt=0`.
  - outputs: `lcd_e=0`, `lcd_rs=0`, `lcd_db=0x00`, `lcd_rw=0`, `busy=0`, `done=0`, `timer_enable=0`, `timer_disable=1`.
- Unused state encodings return to IDLE.

## Timing
- `start` at edge k: SETUP and `busy=1` from k+1. `lcd_rs`/`lcd_db` are valid from k+1.
- Tick arrival is controlled by the timer. After `timer_enable` rises the timer spends one cycle leaving its idle state, so the first tick arrives one timer period plus roughly one cycle later; the block does not compensate.
- E high time equals exactly PULSE_TICKS tick periods in clock edges, measured tick-edge to tick-edge. SETUP and HOLD are the same, except for the first-tick latency above.
- `done` is asserted one cycle after the final WAIT tick. IDLE follows the next cycle, so a back-to-back `start` may be asserted in the cycle after `done` and is accepted there.
- A tick coinciding with a state exit is consumed by the exiting state, not counted by the next.

## Test plan
- Reset mid-PULSE: drop `rst` while `lcd_e=1` -> next cycle `lcd_e=0`, `busy=0`, `lcd_db=0x00`, `timer_disable=1`. Then `start` with data 0x41 completes normally.
- Data write, rs=1, data 0x48, tick every 200 cycles -> `lcd_db=0x48` and `lcd_rs=1` before E. `lcd_e` high exactly 2 tick periods (400 cycles). 10 ticks of WAIT, then a single `done` pulse.
- Command 0x01, rs=0 -> WAIT spans 410 ticks. Command 0x28 -> WAIT spans 10 ticks. Command 0x01 with rs=1 -> 10 ticks.
- `start` pulsed during SETUP, WAIT and DONE -> ignored: exactly one E pulse, `lcd_db` unchanged, one `done`.
- Back-to-back: `start` in the cycle after `done` with 0x0C -> accepted immediately, second E pulse carries 0x0C.
- Tick coincident with the last-tick boundary, and tick stuck low for 1000 cycles in SETUP -> exits exactly at the Nth tick; stays in SETUP with `busy=1` and `lcd_e=0`, no spurious `done`.
